main_controller: RTL and testbench
==================================

Name: main_controller

Overview:
- Top-level sequencing FSM of the vending machine.
- Accepts a validated item selection, then waits a bounded time for a currency-available indication.
- On success, issues a single-cycle dispense_enable to the dispense mechanism.
- cfg_mode (service/configuration) suppresses all vending activity and forces the controller idle.

Parameters:
- TIMEOUT_CYCLES, 16: number of clock edges after an accepted selection during which currency is still accepted. Legal range ≥ 1.
- CNT_W, $clog2(TIMEOUT_CYCLES)+1: width of the internal timeout counter. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- cfg_mode  input  1  configuration mode; high = vending disabled.
- selection_valid  input  1  level/pulse; high on a sampled edge = valid item selected.
- currency_avail  input  1  level/pulse; high on a sampled edge = sufficient currency present.
- dispense_enable  output  1  registered; one-cycle pulse commanding dispense.

Behaviour:
- Single clock; reset is asynchronous and active-low (rstn). All other logic is synchronous to clk rising edge.
- Reset (rstn=0, immediate, any time incl. mid-transaction):
  - state=IDLE, timeout counter=0, dispense_enable=0.
  - Pending selection is discarded.
- States: IDLE, SELECTED, DISPENSE (2-bit encoding; unused codes → IDLE).
- Priority at each edge: cfg_mode > state transition logic.
- cfg_mode=1 sampled at any edge:
  - next state=IDLE, counter=0, dispense_enable=0 from that edge.
  - Selection and currency are ignored while cfg_mode=1.
  - An in-progress DISPENSE pulse is truncated (low after that edge).
- IDLE:
  - selection_valid=1 → SELECTED, counter=0.
  - currency_avail alone is ignored (no credit stored, stay IDLE).
  - Simultaneous selection_valid and currency_avail → SELECTED only; the coin is not counted.
- SELECTED:
  - currency_avail=1 → DISPENSE.
  - Else if counter==TIMEOUT_CYCLES-1 → IDLE (timeout, selection dropped).
  - Else counter+1.
  - selection_valid=1 without currency restarts the counter at 0 (reselection).
  - Currency wins over timeout on the same edge.
- DISPENSE: lasts exactly one cycle; unconditional → IDLE at next edge (unless reset).
  - Inputs during DISPENSE are ignored; a new selection must be presented after return to IDLE.
- dispense_enable = registered (next_state==DISPENSE).
  - High for exactly the one clock cycle following the edge that sampled currency in SELECTED.
  - Low in all other cycles.
- Latency: selection edge N, currency edge M (N<M≤N+TIMEOUT_CYCLES) → dispense_enable high from edge M to edge M+1.
- Counter saturates logic-wise; it never wraps, since the timeout forces IDLE before overflow.
- No combinational path from inputs to dispense_enable.

Test Plan:
- Normal vend: reset, selection_valid 1 cycle, idle 1 cycle, currency_avail 1 cycle → dispense_enable=1 for exactly one cycle following the currency edge, then 0; state back to IDLE.
- Selection without coin: selection_valid 1 cycle, then no inputs for TIMEOUT_CYCLES+2 cycles → dispense_enable stays 0. A later currency_avail pulse → still 0 (timed out).
- Coin without selection: from IDLE, currency_avail 1 cycle, wait 3 cycles → dispense_enable=0. Then selection_valid 1 cycle → SELECTED; no dispense until a new currency pulse.
- Config mode: cfg_mode=1 with selection_valid=1 and currency_avail=1 for 2 cycles, then cfg_mode=0 → dispense_enable=0 throughout and state IDLE afterwards. Separately, cfg_mode asserted while SELECTED → IDLE; a subsequent coin produces no dispense.
- Boundary timing: currency on edge N+TIMEOUT_CYCLES → dispense=1. Currency on edge N+TIMEOUT_CYCLES+1 → no dispense. Reselection at edge N+10 extends the window to N+10+TIMEOUT_CYCLES.
- Async reset mid-operation: rstn=0 between clock edges while in SELECTED, released 2 cycles later, then currency_avail → dispense_enable=0 (selection lost); dispense_enable forced low immediately if reset hits during DISPENSE.

Source files
------------

// File: rtl/main_controller.sv
// main_controller: top-level vending sequencer.
// Takes an item selection and then waits a bounded window for currency.
// When currency arrives in time, it raises a registered one-cycle dispense pulse.
// Configuration mode overrides everything and holds the controller idle.
module main_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic cfg_mode,
  input  logic selection_valid,
  input  logic currency_avail,
  output logic dispense_enable
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SELECTED = 2'b01,
    ST_DISPENSE = 2'b10
  } state_t;

  // The window closes on the edge where the counter reaches the last value.
  // Currency sampled on that same edge is still accepted.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dispense;

  // Sequencing FSM: the state, the timeout counter and the registered dispense pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= LP_CNT_ZERO;
      r_dispense <= 1'b0;
    end else if (cfg_mode) begin
      // Service mode drops any pending selection.
      // It also cuts off a dispense pulse that is in flight.
      r_state    <= ST_IDLE;
      r_cnt      <= LP_CNT_ZERO;
      r_dispense <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Currency seen in IDLE is not stored as credit.
          if (selection_valid) begin
            r_state    <= ST_SELECTED;
            r_cnt      <= LP_CNT_ZERO;
            r_dispense <= 1'b0;
          end else begin
            r_state    <= ST_IDLE;
            r_cnt      <= LP_CNT_ZERO;
            r_dispense <= 1'b0;
          end
        end
        ST_SELECTED: begin
          if (currency_avail) begin
            // Currency takes priority over the timeout on the same edge.
            r_state    <= ST_DISPENSE;
            r_cnt      <= LP_CNT_ZERO;
            r_dispense <= 1'b1;
          end else if (selection_valid) begin
            // A reselection restarts the window.
            r_state    <= ST_SELECTED;
            r_cnt      <= LP_CNT_ZERO;
            r_dispense <= 1'b0;
          end else if (r_cnt == LP_CNT_LAST) begin
            // The window has expired, so the selection is dropped.
            r_state    <= ST_IDLE;
            r_cnt      <= LP_CNT_ZERO;
            r_dispense <= 1'b0;
          end else begin
            r_state    <= ST_SELECTED;
            r_cnt      <= r_cnt + LP_CNT_ONE;
            r_dispense <= 1'b0;
          end
        end
        ST_DISPENSE: begin
          // The pulse is a single cycle.
          // Inputs are ignored until the controller is back in IDLE.
          r_state    <= ST_IDLE;
          r_cnt      <= LP_CNT_ZERO;
          r_dispense <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= LP_CNT_ZERO;
          r_dispense <= 1'b0;
        end
      endcase
    end
  end

  assign dispense_enable = r_dispense;

endmodule

// File: tb/tb_main_controller.sv
// tb_main_controller: directed bench for main_controller with TIMEOUT_CYCLES = 16.
module tb_main_controller;

  localparam int T = 16;

  logic clk;
  logic rstn;
  logic cfg_mode;
  logic selection_valid;
  logic currency_avail;
  logic dispense_enable;

  int n_tests;
  int n_fail;

  main_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_mode        (cfg_mode),
    .selection_valid (selection_valid),
    .currency_avail  (currency_avail),
    .dispense_enable (dispense_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts at a negedge and drives the inputs.
  // One rising edge samples them, and the task returns at the following negedge.
  task automatic step(input logic s, input logic c, input logic m);
    selection_valid = s;
    currency_avail  = c;
    cfg_mode        = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input logic exp, input string tag);
    n_tests++;
    assert (dispense_enable === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, dispense_enable, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn = 1'b0;
    cfg_mode = 1'b0;
    selection_valid = 1'b0;
    currency_avail = 1'b0;
    repeat (2) @(negedge clk);
    chk(1'b0, "reset_state");
    rstn = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk(1'b0, "post_reset_idle");

    // Normal vend: a selection, one idle cycle, then currency.
    step(1'b1, 1'b0, 1'b0); chk(1'b0, "vend_sel");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "vend_wait");
    step(1'b0, 1'b1, 1'b0); chk(1'b1, "vend_pulse");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "vend_pulse_end");

    // Selection with no coin times out, and a late coin does nothing.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < T + 2; i++) begin
      step(1'b0, 1'b0, 1'b0); chk(1'b0, "timeout_wait");
    end
    step(1'b0, 1'b1, 1'b0); chk(1'b0, "late_coin");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "late_coin_after");

    // A coin with no selection is not credited.
    step(1'b0, 1'b1, 1'b0); chk(1'b0, "coin_no_sel");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0); chk(1'b0, "coin_no_sel_wait");
    end
    step(1'b1, 1'b0, 1'b0); chk(1'b0, "sel_after_coin");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "no_credit");
    step(1'b0, 1'b1, 1'b0); chk(1'b1, "new_coin_vends");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "new_coin_end");

    // Config mode blocks all activity and leaves the controller idle.
    step(1'b1, 1'b1, 1'b1); chk(1'b0, "cfg_all_hi_1");
    step(1'b1, 1'b1, 1'b1); chk(1'b0, "cfg_all_hi_2");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "cfg_exit");
    step(1'b0, 1'b1, 1'b0); chk(1'b0, "cfg_left_idle");
    step(1'b1, 1'b0, 1'b0); chk(1'b0, "cfg_sel");
    step(1'b0, 1'b0, 1'b1); chk(1'b0, "cfg_in_selected");
    step(1'b0, 1'b1, 1'b0); chk(1'b0, "cfg_coin_after");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "cfg_coin_after2");
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1); chk(1'b0, "cfg_beats_coin");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "cfg_beats_coin2");

    // Window boundary: a coin at edge N+T is accepted.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < T - 1; i++) step(1'b0, 1'b0, 1'b0);
    chk(1'b0, "edge_window_wait");
    step(1'b0, 1'b1, 1'b0); chk(1'b1, "edge_N_plus_T");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "edge_N_plus_T_end");

    // Window boundary: a coin at edge N+T+1 is rejected.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < T; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk(1'b0, "edge_N_plus_T_plus_1");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "edge_late_end");

    // Reselecting at edge N+10 moves the window to N+10+T.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < T - 1; i++) step(1'b0, 1'b0, 1'b0);
    chk(1'b0, "resel_wait");
    step(1'b0, 1'b1, 1'b0); chk(1'b1, "resel_extended");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "resel_end");

    // A selection and a coin together in IDLE select the item only.
    step(1'b1, 1'b1, 1'b0); chk(1'b0, "sel_coin_same_edge");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "sel_coin_no_credit");
    step(1'b0, 1'b1, 1'b0); chk(1'b1, "sel_coin_then_coin");

    // Inputs seen during DISPENSE are ignored.
    step(1'b1, 1'b1, 1'b0); chk(1'b0, "dispense_single");
    step(1'b0, 1'b1, 1'b0); chk(1'b0, "sel_in_dispense_ignored");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "dispense_ignore_end");

    // An async reset in SELECTED drops the selection.
    step(1'b1, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1 chk(1'b0, "rst_in_selected");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b1, 1'b0); chk(1'b0, "rst_selection_lost");
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "rst_selection_lost2");

    // An async reset during DISPENSE clears the pulse at once.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk(1'b1, "pre_rst_dispense");
    #1 rstn = 1'b0;
    #1 chk(1'b0, "rst_kills_dispense");
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b0, 1'b0); chk(1'b0, "rst_dispense_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
